seq_pipe_sub2_2stage: RTL

- Two-stage pipelined subtractor; computes in0 - in1 over WIDTH bits.
- Stage 0 produces the low half and its borrow; stage 1 produces the high half with borrow-in.
- Unlike the free-running add pipeline, every stage carries a valid bit with valid/ready backpressure, so it can sit between elastic producers and consumers in the datapath.
- Low half is exposed early (out_lsn), one cycle before the full result.

---
 rtl/seq_pipe_sub2_pkg.sv | 25 ++
 rtl/seq_pipe_sub2_2stage_sub_half_borrow.sv | 16 +
 rtl/seq_pipe_sub2_2stage.sv | 117 +++++++++++
 3 files changed

// File: rtl/seq_pipe_sub2_pkg.sv
// Shared constants and stage-payload layouts for the two-stage pipelined subtractor.
package seq_pipe_sub2_pkg;

    localparam int DEF_WIDTH = 8;

    function automatic int half_w(input int w);
        return w / 2;
    endfunction

    localparam int DEF_H = half_w(DEF_WIDTH);

    // Payload layouts at the default width; the top re-declares them against its own WIDTH.
    typedef struct packed {
        logic [DEF_WIDTH-1:0] in0;
        logic [DEF_WIDTH-1:0] in1;
    } x0_pay_t;

    typedef struct packed {
        logic [DEF_H-1:0] in0_msh;
        logic [DEF_H-1:0] in1_msh;
        logic [DEF_H-1:0] lsh;
        logic             b0;
    } x1_pay_t;

endpackage

// File: rtl/seq_pipe_sub2_2stage_sub_half_borrow.sv
// Combinational W-bit subtractor with borrow-in and borrow-out: {bout, d} = a - b - bin.
module sub_half_borrow #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic [W-1:0] d,
    output logic         bout
);

    always_comb begin
        {bout, d} = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    end

endmodule

// File: rtl/seq_pipe_sub2_2stage.sv
// Two-stage elastic subtractor (in0 - in1): low half in stage 0, high half with borrow in stage 1.
// Optional macro SEQ_PIPE_SUB2_SAT_EN clamps underflowing results to zero in stage 1.
module seq_pipe_sub2_2stage
    import seq_pipe_sub2_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_val,
    output logic               in_rdy,
    input  logic [WIDTH-1:0]   in0,
    input  logic [WIDTH-1:0]   in1,
    output logic               lsn_val,
    output logic [WIDTH/2-1:0] out_lsn,
    output logic               out_val,
    input  logic               out_rdy,
    output logic [WIDTH-1:0]   out,
    output logic               out_borrow
);

    localparam int H = half_w(WIDTH);

    typedef struct packed {
        logic [WIDTH-1:0] in0;
        logic [WIDTH-1:0] in1;
    } x0_t;

    typedef struct packed {
        logic [H-1:0] in0_msh;
        logic [H-1:0] in1_msh;
        logic [H-1:0] lsh;
        logic         b0;
    } x1_t;

    logic vld_p0_q, vld_p0_d;
    logic vld_p1_q, vld_p1_d;
    x0_t  data_p0_q, data_p0_d;
    x1_t  data_p1_q, data_p1_d;

    logic         x1_adv;
    logic         x0_adv;
    logic [H-1:0] lsh_p0;
    logic         b0_p0;
    logic [H-1:0] msh_p1;
    logic         b1_p1;

    // Stage 0: low-half subtract straight from the stage-0 registers
    sub_half_borrow #(.W(H)) u_sub_lo (
        .a    (data_p0_q.in0[H-1:0]),
        .b    (data_p0_q.in1[H-1:0]),
        .bin  (1'b0),
        .d    (lsh_p0),
        .bout (b0_p0)
    );

    // Stage 1: high half consumes the borrow captured alongside the low half
    sub_half_borrow #(.W(H)) u_sub_hi (
        .a    (data_p1_q.in0_msh),
        .b    (data_p1_q.in1_msh),
        .bin  (data_p1_q.b0),
        .d    (msh_p1),
        .bout (b1_p1)
    );

    always_comb begin
        x1_adv = out_rdy || !vld_p1_q;
        x0_adv = vld_p0_q && x1_adv;
        in_rdy = !vld_p0_q || x1_adv;

        vld_p0_d  = in_rdy ? in_val : vld_p0_q;
        data_p0_d = data_p0_q;
        if (in_val && in_rdy) begin
            data_p0_d.in0 = in0;
            data_p0_d.in1 = in1;
        end

        vld_p1_d  = x1_adv ? vld_p0_q : vld_p1_q;
        data_p1_d = data_p1_q;
        if (x0_adv) begin
            data_p1_d.in0_msh = data_p0_q.in0[WIDTH-1:H];
            data_p1_d.in1_msh = data_p0_q.in1[WIDTH-1:H];
            data_p1_d.lsh     = lsh_p0;
            data_p1_d.b0      = b0_p0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0_q  <= 1'b0;
            vld_p1_q  <= 1'b0;
            data_p0_q <= '0;
            data_p1_q <= '0;
        end else begin
            vld_p0_q  <= vld_p0_d;
            vld_p1_q  <= vld_p1_d;
            data_p0_q <= data_p0_d;
            data_p1_q <= data_p1_d;
        end
    end

    assign lsn_val    = vld_p0_q;
    assign out_lsn    = lsh_p0;
    assign out_val    = vld_p1_q;
    assign out_borrow = b1_p1;

`ifdef SEQ_PIPE_SUB2_SAT_EN
    function automatic logic [WIDTH-1:0] sat_floor(input logic [WIDTH-1:0] raw, input logic uf);
        return uf ? '0 : raw;
    endfunction

    assign out = sat_floor({msh_p1, data_p1_q.lsh}, b1_p1);
`else
    assign out = {msh_p1, data_p1_q.lsh};
`endif

endmodule
